// File: rtl/snake_body_sequencer.sv
// Snake body store and per-tick move sequencer: shifts the body, steps the head with
// wrap-around, sweeps for self-collision and flags target hits for growth.
module snake_body_sequencer #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 4,
    parameter int GRID_H   = 160,
    parameter int GRID_V   = 120,
    parameter int START_H  = 80,
    parameter int START_V  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gameclock,
    input  logic [1:0] master_state,
    input  logic [1:0] navigation_state,
    input  logic [7:0] rand_addrh,
    input  logic [6:0] rand_addrv,
    input  logic [4:0] seg_idx,
    output logic [7:0] seg_h,
    output logic [6:0] seg_v,
    output logic [7:0] head_h,
    output logic [6:0] head_v,
    output logic [5:0] length,
    output logic       busy,
    output logic       reached_target,
    output logic       collision
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_HEAD  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0] H_MAX = 8'(GRID_H - 1);
    localparam logic [6:0] V_MAX = 7'(GRID_V - 1);

    logic [7:0] body_h [MAX_LEN];
    logic [6:0] body_v [MAX_LEN];
    logic [2:0] state;
    logic [4:0] idx;
    logic [1:0] dir;
    logic       grow_pending;
    logic [7:0] next_h;
    logic [6:0] next_v;
    logic       head_hit;
    logic       body_hit;
    logic       init;

    assign head_h         = body_h[0];
    assign head_v         = body_v[0];
    assign busy           = (state != S_IDLE);
    assign head_hit       = (body_h[0] == rand_addrh) && (body_v[0] == rand_addrv);
    assign body_hit       = (body_h[0] == body_h[idx]) && (body_v[0] == body_v[idx]);
    assign reached_target = (state == S_DONE) && head_hit;
    assign init           = reset || (state == S_IDLE && master_state == 2'd0);

    // Row 0 is the top of the grid, so "up" decrements V.
    always_comb begin
        next_h = body_h[0];
        next_v = body_v[0];
        case (dir)
            2'd0:    next_v = (body_v[0] == 7'd0) ? V_MAX : body_v[0] - 7'd1;
            2'd1:    next_h = (body_h[0] == H_MAX) ? 8'd0 : body_h[0] + 8'd1;
            2'd2:    next_v = (body_v[0] == V_MAX) ? 7'd0 : body_v[0] + 7'd1;
            default: next_h = (body_h[0] == 8'd0) ? H_MAX : body_h[0] - 8'd1;
        endcase
    end

    // Read port is only cleared by a true reset so the display keeps working in idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_h <= '0;
            seg_v <= '0;
        end else begin
            seg_h <= body_h[seg_idx];
            seg_v <= body_v[seg_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                body_h[i] <= (i < INIT_LEN) ? 8'(START_H - i) : 8'd0;
                body_v[i] <= (i < INIT_LEN) ? 7'(START_V) : 7'd0;
            end
            length       <= 6'(INIT_LEN);
            dir          <= 2'd1;
            grow_pending <= 1'b0;
            collision    <= 1'b0;
            idx          <= '0;
            state        <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gameclock && master_state == 2'd1 && !collision) begin
                        state <= S_SHIFT;
                        // Reversal would fold the head onto the neck; keep the old heading.
                        if (navigation_state != (dir ^ 2'd2))
                            dir <= navigation_state;
                        if (grow_pending && length < 6'(MAX_LEN)) begin
                            length <= length + 6'd1;
                            idx    <= length[4:0];
                        end else begin
                            idx    <= 5'(length - 6'd1);
                        end
                        grow_pending <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    body_h[idx] <= body_h[idx - 5'd1];
                    body_v[idx] <= body_v[idx - 5'd1];
                    idx         <= idx - 5'd1;
                    if (idx == 5'd1)
                        state <= S_HEAD;
                end
                S_HEAD: begin
                    body_h[0] <= next_h;
                    body_v[0] <= next_v;
                    idx       <= 5'd1;
                    state     <= S_CHECK;
                end
                S_CHECK: begin
                    if (body_hit)
                        collision <= 1'b1;
                    if (idx == 5'(length - 6'd1))
                        state <= S_DONE;
                    else
                        idx <= idx + 5'd1;
                end
                S_DONE: begin
                    if (head_hit)
                        grow_pending <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_body_sequencer.sv
// Directed bench for snake_body_sequencer: moves, growth, wrap, collision,
// dropped ticks, re-init and mid-sweep reset.
module tb_snake_body_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       gameclock;
    logic [1:0] master_state;
    logic [1:0] navigation_state;
    logic [7:0] rand_addrh;
    logic [6:0] rand_addrv;
    logic [4:0] seg_idx;
    logic [7:0] seg_h;
    logic [6:0] seg_v;
    logic [7:0] head_h;
    logic [6:0] head_v;
    logic [5:0] length;
    logic       busy;
    logic       reached_target;
    logic       collision;

    int checks = 0;
    int errors = 0;

    snake_body_sequencer dut (
        .clk(clk), .reset(reset), .gameclock(gameclock),
        .master_state(master_state), .navigation_state(navigation_state),
        .rand_addrh(rand_addrh), .rand_addrv(rand_addrv), .seg_idx(seg_idx),
        .seg_h(seg_h), .seg_v(seg_v), .head_h(head_h), .head_v(head_v),
        .length(length), .busy(busy), .reached_target(reached_target),
        .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; gameclock = 1'b0; master_state = 2'd0; navigation_state = 2'd1;
        rand_addrh = 8'd200; rand_addrv = 7'd127; seg_idx = 5'd0;
        step(); step();
        reset = 1'b0; master_state = 2'd1;
    endtask

    // One tick, then count busy cycles and note which busy cycle showed the target pulse.
    task automatic tick(input logic [1:0] nav, output int cycles, output int reached_at);
        navigation_state = nav;
        gameclock = 1'b1;
        step();
        gameclock = 1'b0;
        cycles = 0;
        reached_at = 0;
        while (busy && cycles < 200) begin
            cycles++;
            if (reached_target) reached_at = cycles;
            step();
        end
        if (cycles >= 200) check("tick_timeout", 32'(busy), 0);
    endtask

    task automatic read_seg(input logic [4:0] i);
        seg_idx = i;
        step();
    endtask

    initial begin
        int c, r;
        reset = 1'b1; gameclock = 1'b0; master_state = 2'd0; navigation_state = 2'd1;
        rand_addrh = 8'd200; rand_addrv = 7'd127; seg_idx = 5'd0;
        step();
        check("rst_len", 32'(length), 4);
        check("rst_head_h", 32'(head_h), 80);
        check("rst_head_v", 32'(head_v), 60);
        check("rst_busy", 32'(busy), 0);
        check("rst_coll", 32'(collision), 0);
        check("rst_reached", 32'(reached_target), 0);
        check("rst_seg_h", 32'(seg_h), 0);
        check("rst_seg_v", 32'(seg_v), 0);

        // Single move right from reset
        do_reset();
        tick(2'd1, c, r);
        check("move_busy_cycles", 32'(c), 8);
        check("move_head_h", 32'(head_h), 81);
        check("move_head_v", 32'(head_v), 60);
        check("move_len", 32'(length), 4);
        read_seg(5'd3);
        check("move_seg3_h", 32'(seg_h), 78);
        check("move_seg3_v", 32'(seg_v), 60);
        read_seg(5'd1);
        check("move_seg1_h", 32'(seg_h), 80);

        // Target hit then growth
        do_reset();
        rand_addrh = 8'd81; rand_addrv = 7'd60;
        tick(2'd1, c, r);
        check("hit_reached_at", 32'(r), 8);
        check("hit_len", 32'(length), 4);
        rand_addrh = 8'd200; rand_addrv = 7'd127;
        tick(2'd1, c, r);
        check("grow_busy_cycles", 32'(c), 10);
        check("grow_reached", 32'(r), 0);
        check("grow_len", 32'(length), 5);
        check("grow_head_h", 32'(head_h), 82);
        read_seg(5'd4);
        check("grow_seg4_h", 32'(seg_h), 78);
        check("grow_seg4_v", 32'(seg_v), 60);

        // Reset during SHIFT wins on the next edge
        navigation_state = 2'd1;
        gameclock = 1'b1; step(); gameclock = 1'b0; step();
        check("midrst_busy_before", 32'(busy), 1);
        reset = 1'b1; step();
        check("midrst_len", 32'(length), 4);
        check("midrst_head_h", 32'(head_h), 80);
        check("midrst_head_v", 32'(head_v), 60);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_coll", 32'(collision), 0);
        reset = 1'b0;

        // Reversal refused; tick during busy dropped; master change mid-sweep ignored
        do_reset();
        tick(2'd3, c, r);
        check("norev_head_h", 32'(head_h), 81);
        check("norev_head_v", 32'(head_v), 60);
        navigation_state = 2'd1;
        gameclock = 1'b1; step(); gameclock = 1'b0;
        step(); step();
        gameclock = 1'b1; master_state = 2'd2; step(); gameclock = 1'b0;
        c = 0;
        while (busy && c < 200) begin c++; step(); end
        step(); step(); step();
        check("drop_busy", 32'(busy), 0);
        check("drop_head_h", 32'(head_h), 82);
        check("drop_len", 32'(length), 4);
        master_state = 2'd0;
        step(); step();
        check("reinit_head_h", 32'(head_h), 80);
        check("reinit_head_v", 32'(head_v), 60);

        // Horizontal wrap
        do_reset();
        for (int i = 0; i < 79; i++) tick(2'd1, c, r);
        check("wrap_pre_h", 32'(head_h), 159);
        tick(2'd1, c, r);
        check("wrap_h", 32'(head_h), 0);
        check("wrap_h_v", 32'(head_v), 60);

        // Vertical wrap
        do_reset();
        for (int i = 0; i < 60; i++) tick(2'd0, c, r);
        check("wrap_pre_v", 32'(head_v), 0);
        tick(2'd0, c, r);
        check("wrap_v", 32'(head_v), 119);
        check("wrap_v_h", 32'(head_h), 80);

        // Self-collision loop at length 5
        do_reset();
        rand_addrh = 8'd81; rand_addrv = 7'd60;
        tick(2'd1, c, r);
        rand_addrh = 8'd200; rand_addrv = 7'd127;
        tick(2'd0, c, r);
        check("loop_len", 32'(length), 5);
        tick(2'd1, c, r);
        tick(2'd2, c, r);
        check("loop_coll_before", 32'(collision), 0);
        tick(2'd3, c, r);
        check("loop_coll", 32'(collision), 1);
        check("loop_head_h", 32'(head_h), 81);
        check("loop_head_v", 32'(head_v), 60);
        tick(2'd0, c, r);
        check("loop_ignored_cycles", 32'(c), 0);
        check("loop_ignored_busy", 32'(busy), 0);
        check("loop_ignored_head_v", 32'(head_v), 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
